muldiv_unit: RTL

- Parametrised RV32M/RV64M execution unit sitting beside the integer ALU in the out-of-order core.
- Accepts one M-extension op at a time from its reservation station and computes it over multiple cycles: MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU.
- Presents the result with its ROB index on the common data bus through a valid/ready handshake.
- Flushed on branch mispredict.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_unit_div_core.sv | 80 ++++++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode codes, FSM state encoding and opcode helpers for the RV32M/RV64M muldiv_unit.
// M-extension codes sit in 6'h30..6'h37, clear of the integer ALU opcode range.
package muldiv_unit_pkg;

  localparam logic [5:0] OP_MUL    = 6'h30;
  localparam logic [5:0] OP_MULH   = 6'h31;
  localparam logic [5:0] OP_MULHSU = 6'h32;
  localparam logic [5:0] OP_MULHU  = 6'h33;
  localparam logic [5:0] OP_DIV    = 6'h34;
  localparam logic [5:0] OP_DIVU   = 6'h35;
  localparam logic [5:0] OP_REM    = 6'h36;
  localparam logic [5:0] OP_REMU   = 6'h37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [5:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, XLEN cycles after start_i.
// done_o pulses for one cycle once quotient_o/remainder_o are final.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN:0]   r_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Divisor of zero never restores, giving all-ones quotient and remainder = dividend.
  assign r_sh = {rem_q, quo_q[XLEN-1]};
  assign ge   = (r_sh >= {1'b0, dvs_q});
  assign diff = r_sh[XLEN-1:0] - dvs_q;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = CW'(XLEN);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = {quo_q[XLEN-2:0], ge};
      rem_d = ge ? diff : r_sh[XLEN-1:0];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execution unit with CDB valid/ready result port.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete one cycle after accept.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 flush_in,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [5:0]           opcode,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [ROB_IDX_W-1:0] rob_index,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [XLEN-1:0]      res,
  output logic [ROB_IDX_W-1:0] rob_index_out
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e                 state_q, state_d;
  logic [5:0]             op_q, op_d;
  logic [XLEN-1:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic [ROB_IDX_W-1:0]   rob_q, rob_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   accept, div_start, div_done, sgn_in;
  logic [XLEN-1:0]        mag1, mag2, div_quo, div_rem, mul_res, div_res;
  logic [2*XLEN-1:0]      a_ext, b_ext, prod;
  logic                   neg_a, neg_b, q_neg;

  assign accept = issue_valid && (state_q == ST_IDLE) && (is_mul_op(opcode) || is_div_op(opcode));
  assign sgn_in = is_signed_div_op(opcode);
  assign mag1   = (sgn_in && val1[XLEN-1]) ? -val1 : val1;
  assign mag2   = (sgn_in && val2[XLEN-1]) ? -val2 : val2;

`ifdef MULDIV_FAST_SPECIAL_EN
  logic            special_q, special_d, in_special;
  logic [XLEN-1:0] spec_res;
  assign in_special = (val2 == '0) ||
                      (sgn_in && (val1 == {1'b1, {(XLEN-1){1'b0}}}) && (val2 == '1));
  assign spec_res   = (b_q == '0) ? (is_rem_op(op_q) ? a_q : '1)
                                  : (is_rem_op(op_q) ? '0 : a_q);
  assign div_start  = accept && is_div_op(opcode) && !in_special && !flush_in;
`else
  assign div_start  = accept && is_div_op(opcode) && !flush_in;
`endif

  div_core #(.XLEN(XLEN)) u_div_core (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .flush_i     (flush_in),
    .start_i     (div_start),
    .dividend_i  (mag1),
    .divisor_i   (mag2),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Two's-complement product of extended operands gives every MUL* variant from one multiply.
  assign a_ext   = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) ? {{XLEN{a_q[XLEN-1]}}, a_q}
                                                             : {{XLEN{1'b0}}, a_q};
  assign b_ext   = (op_q == OP_MULH) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign neg_a   = is_signed_div_op(op_q) && a_q[XLEN-1];
  assign neg_b   = is_signed_div_op(op_q) && b_q[XLEN-1];
  assign q_neg   = (neg_a ^ neg_b) && (b_q != '0);
  assign div_res = is_rem_op(op_q) ? (neg_a ? -div_rem : div_rem)
                                   : (q_neg ? -div_quo : div_quo);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rob_d   = rob_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef MULDIV_FAST_SPECIAL_EN
    special_d = special_q;
`endif
    if (flush_in) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef MULDIV_FAST_SPECIAL_EN
      special_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          op_d  = opcode;
          a_d   = val1;
          b_d   = val2;
          rob_d = rob_index;
          if (is_mul_op(opcode)) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else begin
            state_d = ST_DIV;
`ifdef MULDIV_FAST_SPECIAL_EN
            special_d = in_special;
`endif
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            res_d   = mul_res;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DIV: begin
`ifdef MULDIV_FAST_SPECIAL_EN
          if (special_q) begin
            res_d     = spec_res;
            special_d = 1'b0;
            state_d   = ST_DONE;
          end else
`endif
          if (div_done) begin
            res_d   = div_res;
            state_d = ST_DONE;
          end
        end
        ST_DONE: if (res_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rob_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rob_q   <= rob_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) special_q <= 1'b0;
    else           special_q <= special_d;
  end
`endif

  assign issue_ready   = (state_q == ST_IDLE);
  assign res_valid     = (state_q == ST_DONE);
  assign res           = res_q;
  assign rob_index_out = rob_q;

endmodule
